// File: rtl/cpu3_pkg.sv
// Shared definitions for the issue stage: entry layout, functional-unit
// one-hot codes, scoreboard geometry and small helpers.
package cpu3_pkg;

  localparam int unsigned NWAIT  = 4;
  localparam int unsigned NREG   = 64;
  localparam int unsigned NMOD   = 10;
  localparam int unsigned RW     = 6;
  localparam int unsigned PC_W   = 14;
  localparam int unsigned OPE_W  = 6;
  localparam int unsigned IMM_W  = 16;
  localparam int unsigned OPR_W  = 5;
  localparam int unsigned CTRL_W = 4;
  localparam int unsigned EW     = PC_W + OPE_W + 3 * RW + IMM_W + OPR_W + CTRL_W + NMOD;

  // r0 (bit 0) and f0 (bit 32) are hardwired and never tracked.
  localparam logic [NREG-1:0] MASK = ~((64'd1 << 32) | 64'd1);

  typedef enum logic [NMOD-1:0] {
    MOD_B    = 10'b00_0000_0001,
    MOD_IO   = 10'b00_0000_0010,
    MOD_MEM  = 10'b00_0000_0100,
    MOD_ALU  = 10'b00_0000_1000,
    MOD_ALU2 = 10'b00_0001_0000,
    MOD_MV   = 10'b00_0010_0000,
    MOD_FAB  = 10'b00_0100_0000,
    MOD_FML  = 10'b00_1000_0000,
    MOD_FDS  = 10'b01_0000_0000,
    MOD_FET  = 10'b10_0000_0000
  } mod_e;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [OPE_W-1:0]  ope;
    logic [RW-1:0]     ds;
    logic [RW-1:0]     dt;
    logic [RW-1:0]     dd;
    logic [IMM_W-1:0]  imm;
    logic [OPR_W-1:0]  opr;
    logic [CTRL_W-1:0] ctrl;
    logic [NMOD-1:0]   mod;
  } entry_t;

  function automatic logic is_onehot(input logic [NMOD-1:0] m);
    return (m != '0) && ((m & (m - 1'b1)) == '0);
  endfunction

  function automatic logic [NREG-1:0] reg_bit(input logic [RW-1:0] r);
    return MASK & (NREG'(1) << r);
  endfunction

endpackage

// File: rtl/sched_hazard.sv
// Scoreboard check for one window entry: RAW/WAW hazard against pending
// writes, plus the board bit this entry will set when it issues.
module sched_hazard
  import cpu3_pkg::*;
(
  input  logic [RW-1:0]   ds,
  input  logic [RW-1:0]   dt,
  input  logic [RW-1:0]   dd,
  input  logic [NREG-1:0] board,
  output logic            hazard,
  output logic [NREG-1:0] dest
);

  assign dest   = reg_bit(dd);
  assign hazard = |(board & (reg_bit(ds) | reg_bit(dt) | dest));

endmodule

// File: rtl/issue_scheduler.sv
// In-order dual-issue scheduler: 4-entry compacting wait window, 64-bit
// pending-write scoreboard, registered issue of up to two entries per cycle.
module issue_scheduler
  import cpu3_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic [1:0]        in_vld,
  input  logic [2*EW-1:0]   in_data,
  output logic              in_rdy,
  input  logic              flush,
  input  logic [NMOD-1:0]   unit_rdy,
  input  logic [1:0]        wb_vld,
  input  logic [2*RW-1:0]   wb_reg,
  output logic [1:0]        iss_vld,
  output logic [2*EW-1:0]   iss_data,
  output logic [NREG-1:0]   board,
  output logic [7:0]        err
);

  localparam int unsigned CW = $clog2(NWAIT + 1);
  localparam int unsigned IW = $clog2(NWAIT);

  entry_t          win     [NWAIT];
  entry_t          win_nxt [NWAIT];
  logic [CW-1:0]   cnt, cnt_nxt, nis, nacc, surv;
  logic [IW-1:0]   idx;
  entry_t          lane0, lane1, new0, iss0, iss1;
  logic            haz0, haz1, go0, go1, accept;
  logic [NREG-1:0] dest0, dest1, wb_clr, board_nxt;
  logic [2:0]      err_q, err_set;

  assign lane0  = in_data[EW-1:0];
  assign lane1  = in_data[2*EW-1:EW];
  assign new0   = in_vld[0] ? lane0 : lane1;
  assign in_rdy = cnt <= CW'(NWAIT - 2);
  assign accept = in_rdy && !flush;

  sched_hazard u_haz0 (
    .ds(win[0].ds), .dt(win[0].dt), .dd(win[0].dd),
    .board(board), .hazard(haz0), .dest(dest0)
  );
  sched_hazard u_haz1 (
    .ds(win[1].ds), .dt(win[1].dt), .dd(win[1].dd),
    .board(board), .hazard(haz1), .dest(dest1)
  );

  assign go0 = !flush && (cnt != '0) && !haz0 && ((unit_rdy & win[0].mod) != '0);
  // Slot1 also must not touch slot0's destination: that write is not yet on the board.
  assign go1 = go0 && (cnt >= CW'(2)) && !haz1 && ((unit_rdy & win[1].mod) != '0)
            && (win[1].mod != win[0].mod) && (win[0].mod != MOD_B)
            && ((dest0 & (reg_bit(win[1].ds) | reg_bit(win[1].dt) | dest1)) == '0);

  assign nis     = CW'(go0) + CW'(go1);
  assign nacc    = accept ? (CW'(in_vld[0]) + CW'(in_vld[1])) : '0;
  assign surv    = cnt - nis;
  assign cnt_nxt = flush ? '0 : surv + nacc;

  // Survivors shift down by the issue count; new lanes land right after them.
  always_comb begin
    win_nxt = win;
    idx     = '0;
    for (int unsigned i = 0; i < NWAIT; i++) begin
      idx = IW'(CW'(i) + nis);
      if (CW'(i) < surv)       win_nxt[i] = win[idx];
      else if (CW'(i) == surv) win_nxt[i] = new0;
      else                     win_nxt[i] = lane1;
    end
  end

  always_comb begin
    wb_clr  = '0;
    err_set = '0;
    for (int unsigned p = 0; p < 2; p++) begin
      if (wb_vld[p]) begin
        wb_clr[wb_reg[p*RW +: RW]] = 1'b1;
        if (!board[wb_reg[p*RW +: RW]]) err_set[1] = 1'b1;
      end
    end
    board_nxt  = (board & ~wb_clr) | (go0 ? dest0 : '0) | (go1 ? dest1 : '0);
    err_set[0] = !flush && (in_vld != '0) && !in_rdy;
    err_set[2] = accept && ((in_vld[0] && !is_onehot(lane0.mod))
                         || (in_vld[1] && !is_onehot(lane1.mod)));
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < NWAIT; i++) win[i] <= '0;
      cnt     <= '0;
      board   <= '0;
      iss_vld <= '0;
      iss0    <= '0;
      iss1    <= '0;
      err_q   <= '0;
    end else begin
      win     <= win_nxt;
      cnt     <= cnt_nxt;
      board   <= board_nxt;
      iss_vld <= {go1, go0};
      iss0    <= go0 ? win[0] : '0;
      iss1    <= go1 ? win[1] : '0;
      err_q   <= err_q | err_set;
    end
  end

  assign iss_data = {iss1, iss0};
  assign err      = {5'b0, err_q};

endmodule

// File: tb/tb_issue_scheduler.sv
// Scoreboard bench for issue_scheduler: a queue-based reference model predicts
// issues, board and error flags; a separate monitor compares DUT outputs.
module tb_issue_scheduler;
  import cpu3_pkg::*;

  logic              clk = 1'b0;
  logic              rstn;
  logic [1:0]        in_vld;
  logic [2*EW-1:0]   in_data;
  logic              in_rdy;
  logic              flush;
  logic [NMOD-1:0]   unit_rdy;
  logic [1:0]        wb_vld;
  logic [2*RW-1:0]   wb_reg;
  logic [1:0]        iss_vld;
  logic [2*EW-1:0]   iss_data;
  logic [NREG-1:0]   board;
  logic [7:0]        err;

  always #5 clk = ~clk;

  issue_scheduler dut (
    .clk(clk), .rstn(rstn), .in_vld(in_vld), .in_data(in_data), .in_rdy(in_rdy),
    .flush(flush), .unit_rdy(unit_rdy), .wb_vld(wb_vld), .wb_reg(wb_reg),
    .iss_vld(iss_vld), .iss_data(iss_data), .board(board), .err(err)
  );

  typedef struct { int slot; entry_t e; } exp_t;
  exp_t        exp_q[$];
  entry_t      wq[$];
  logic [63:0] m_board = '0;
  logic [7:0]  m_err   = '0;
  bit          m_rst   = 1'b1;
  int          n_cmp   = 0;
  int          n_bad   = 0;

  task automatic check(string name, logic [159:0] act, logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit tracked(logic [5:0] r);
    return r[4:0] != 5'd0;
  endfunction

  function automatic bit busy(logic [5:0] r);
    return tracked(r) && m_board[r];
  endfunction

  // Reference model: one clock of the window, applied to the inputs now driven.
  task automatic model_step();
    entry_t      e0, e1;
    entry_t      lane[2];
    bit          go0 = 0, go1 = 0, rdy;
    logic [63:0] nb;
    logic [5:0]  r;
    exp_t        it;
    if (!rstn) begin
      wq.delete(); m_board = '0; m_err = '0; m_rst = 1'b1;
      return;
    end
    m_rst   = 1'b0;
    rdy     = wq.size() <= NWAIT - 2;
    lane[0] = in_data[EW-1:0];
    lane[1] = in_data[2*EW-1:EW];
    if (!flush && wq.size() >= 1) begin
      e0  = wq[0];
      go0 = !busy(e0.ds) && !busy(e0.dt) && !busy(e0.dd) && ((unit_rdy & e0.mod) != 0);
    end
    if (go0 && wq.size() >= 2) begin
      e1  = wq[1];
      go1 = !busy(e1.ds) && !busy(e1.dt) && !busy(e1.dd) && ((unit_rdy & e1.mod) != 0)
         && e1.mod != e0.mod && e0.mod != MOD_B
         && !(tracked(e0.dd) && (e1.ds == e0.dd || e1.dt == e0.dd || e1.dd == e0.dd));
    end
    nb = m_board;
    for (int p = 0; p < 2; p++) if (wb_vld[p]) begin
      r = wb_reg[p*6 +: 6];
      if (!m_board[r]) m_err[1] = 1'b1;
      nb[r] = 1'b0;
    end
    if (go0) begin
      it.slot = 0; it.e = e0; exp_q.push_back(it);
      if (tracked(e0.dd)) nb[e0.dd] = 1'b1;
    end
    if (go1) begin
      it.slot = 1; it.e = e1; exp_q.push_back(it);
      if (tracked(e1.dd)) nb[e1.dd] = 1'b1;
    end
    if (!flush && in_vld != 2'b00 && !rdy) m_err[0] = 1'b1;
    if (flush) wq.delete();
    else begin
      if (go0) void'(wq.pop_front());
      if (go1) void'(wq.pop_front());
      if (rdy) for (int p = 0; p < 2; p++) if (in_vld[p]) begin
        if (!$onehot(lane[p].mod)) m_err[2] = 1'b1;
        wq.push_back(lane[p]);
      end
    end
    m_board = nb;
  endtask

  // Monitor: compare every cycle, popping one expected issue per valid slot.
  initial begin
    exp_t it;
    forever begin
      @(posedge clk); #1;
      check("in_rdy", 160'(in_rdy), 160'(wq.size() <= NWAIT - 2));
      check("board", 160'(board), 160'(m_board));
      check("err", 160'(err), 160'(m_err));
      if (m_rst) check("iss_data_rst", 160'(iss_data), 160'(0));
      for (int s = 0; s < 2; s++) if (iss_vld[s]) begin
        if (exp_q.size() == 0) check($sformatf("iss%0d_unexpected", s), 160'(1), 160'(0));
        else begin
          it = exp_q.pop_front();
          check("iss_slot", 160'(s), 160'(it.slot));
          check("iss_data", 160'(iss_data[s*EW +: EW]), 160'(it.e));
        end
      end
      check("iss_missing", 160'(exp_q.size()), 160'(0));
      exp_q.delete();
    end
  end

  function automatic logic [5:0] rnd_reg();
    return {1'($urandom_range(0, 1)), 3'b000, 2'($urandom_range(0, 3))};
  endfunction

  function automatic entry_t mk(logic [5:0] ds, logic [5:0] dt, logic [5:0] dd, logic [NMOD-1:0] mod);
    logic [95:0] raw = {$urandom, $urandom, $urandom};
    entry_t e;
    e = raw[EW-1:0];
    e.ds = ds; e.dt = dt; e.dd = dd; e.mod = mod;
    return e;
  endfunction

  function automatic entry_t rnd_entry();
    logic [NMOD-1:0] m;
    if ($urandom_range(0, 19) == 0) m = NMOD'($urandom);
    else m = NMOD'(1) << $urandom_range(0, NMOD - 1);
    return mk(rnd_reg(), rnd_reg(), rnd_reg(), m);
  endfunction

  task automatic idle();
    in_vld = '0; in_data = {rnd_entry(), rnd_entry()}; flush = 0;
    unit_rdy = '1; wb_vld = '0; wb_reg = '0;
  endtask

  task automatic lanes(logic [1:0] v, entry_t a, entry_t b);
    in_vld = v; in_data = {b, a};
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
  endtask

  task automatic pick_wb(int p, bit allow_random);
    int q[$];
    for (int b = 0; b < 64; b++) if (m_board[b]) q.push_back(b);
    if (q.size() == 0 && !allow_random) return;
    wb_vld[p] = 1'b1;
    if (q.size() == 0 || (allow_random && $urandom_range(0, 7) == 0))
      wb_reg[p*6 +: 6] = 6'($urandom_range(0, 63));
    else
      wb_reg[p*6 +: 6] = 6'(q[p < q.size() && !allow_random ? p : $urandom_range(0, q.size() - 1)]);
  endtask

  task automatic drain();
    for (int k = 0; k < 8; k++) begin
      idle(); pick_wb(0, 0); pick_wb(1, 0); tick();
    end
    idle();
  endtask

  task automatic do_reset();
    idle(); rstn = 0; tick(); tick(); rstn = 1;
  endtask

  initial begin
    do_reset();

    // Two independent writers issue together one cycle after enqueue.
    lanes(2'b11, mk(6'd1, 6'd2, 6'd3, MOD_ALU), mk(6'd1, 6'd0, 6'd36, MOD_MEM)); tick();
    idle(); tick();
    check("s1_iss_vld", 160'(iss_vld), 160'(2'b11));
    check("s1_board", 160'(board), 160'((64'd1 << 3) | (64'd1 << 36)));
    drain();

    // RAW on the older slot's destination, then on the board until writeback.
    lanes(2'b11, mk(6'd1, 6'd2, 6'd3, MOD_ALU), mk(6'd3, 6'd4, 6'd5, MOD_ALU2)); tick();
    idle(); tick();
    idle(); tick();
    idle(); wb_vld = 2'b01; wb_reg = 12'd3; tick();
    idle(); tick();
    idle(); tick();
    drain();

    // Same unit twice with only that unit ready.
    lanes(2'b11, mk(6'd1, 6'd2, 6'd5, MOD_ALU), mk(6'd1, 6'd2, 6'd6, MOD_ALU)); unit_rdy = MOD_ALU; tick();
    in_vld = '0; tick(); tick(); tick();
    drain();

    // Window fill and overflow with all units stalled.
    idle(); unit_rdy = '0;
    lanes(2'b11, rnd_entry(), rnd_entry()); tick();
    lanes(2'b01, mk(6'd1, 6'd2, 6'd9, MOD_IO), rnd_entry()); tick();
    check("s4_rdy_cnt3", 160'(in_rdy), 160'(0));
    in_vld = '0; flush = 1; tick(); flush = 0;
    lanes(2'b11, mk(6'd1, 6'd2, 6'd9, MOD_IO), mk(6'd1, 6'd2, 6'd10, MOD_FAB)); tick();
    lanes(2'b11, mk(6'd1, 6'd2, 6'd11, MOD_IO), mk(6'd1, 6'd2, 6'd12, MOD_FAB)); tick();
    check("s4_rdy_cnt4", 160'(in_rdy), 160'(0));
    lanes(2'b11, rnd_entry(), rnd_entry()); tick();
    check("s4_err0", 160'(err[0]), 160'(1));
    check("s4_rdy_after", 160'(in_rdy), 160'(0));
    idle(); unit_rdy = '0; flush = 1; tick();
    drain();
    do_reset();

    // Branch at head blocks the follower; flush racing an enqueue.
    lanes(2'b11, mk(6'd0, 6'd0, 6'd0, MOD_B), mk(6'd1, 6'd2, 6'd8, MOD_ALU)); tick();
    idle(); tick();
    check("s5_only_slot0", 160'(iss_vld), 160'(2'b01));
    idle(); tick();
    lanes(2'b11, mk(6'd1, 6'd2, 6'd13, MOD_ALU), mk(6'd1, 6'd2, 6'd14, MOD_FML)); tick();
    lanes(2'b11, rnd_entry(), rnd_entry()); flush = 1; tick();
    check("s5_flush_iss", 160'(iss_vld), 160'(0));
    idle(); tick();
    check("s5_flush_rdy", 160'(in_rdy), 160'(1));
    drain();

    // WAW behind an older r7 writer; r0 destination never marks the board.
    lanes(2'b01, mk(6'd1, 6'd2, 6'd7, MOD_ALU), rnd_entry()); tick();
    lanes(2'b11, mk(6'd1, 6'd2, 6'd7, MOD_ALU2), mk(6'd1, 6'd2, 6'd0, MOD_MV)); tick();
    idle(); wb_vld = 2'b01; wb_reg = 12'd7; tick();
    idle(); tick();
    idle(); tick();
    drain();

    // Randomised traffic with occasional flush, stall and mid-run reset.
    for (int c = 0; c < 3000; c++) begin
      rstn     = ($urandom_range(0, 299) != 0);
      in_vld   = 2'($urandom_range(0, 3));
      in_data  = {rnd_entry(), rnd_entry()};
      flush    = ($urandom_range(0, 15) == 0);
      unit_rdy = ($urandom_range(0, 3) != 0) ? '1 : NMOD'($urandom);
      wb_vld   = '0; wb_reg = '0;
      if ($urandom_range(0, 2) == 0) pick_wb(0, 1);
      if ($urandom_range(0, 3) == 0) pick_wb(1, 1);
      tick();
    end
    rstn = 1;
    idle(); tick(); tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
